// File: rtl/eightbit_serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first,
// through a single full-adder cell as A + ~B + ~bin.
module eightbit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_nb;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  // One full-adder cell on the current LSBs, with the subtrahend inverted.
  assign w_nb       = ~r_sb[0];
  assign w_sum      = r_sa[0] ^ w_nb ^ r_carry;
  assign w_cout     = (r_sa[0] & w_nb) | (r_sa[0] & r_carry) | (w_nb & r_carry);
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_carry <= ~i_bin;
            r_cnt   <= '0;
            r_a_msb <= i_a[WIDTH-1];
            r_b_msb <= i_b[WIDTH-1];
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_res   <= w_res_next;
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          // Last bit: publish the result on the same edge that enters DONE.
          if (r_cnt == LAST_BIT) begin
            r_diff  <= w_res_next;
            r_bout  <= ~w_cout;
            r_ovf   <= (r_a_msb != r_b_msb) & (w_sum != r_a_msb);
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_diff     = r_diff;
  assign o_bout     = r_bout;
  assign o_overflow = r_ovf;
  assign o_busy     = (r_state == ST_SHIFT);
  assign o_done     = (r_state == ST_DONE);

endmodule

// File: doc/eightbit_serial_subtractor.md
Name: eightbit_serial_subtractor

Overview:
- Bit-serial 8-bit subtractor: D = A - B - bin, processed LSB first through one full-adder cell in two's complement (A + ~B + ~bin).
- Sequential inverse-operation companion to the combinational 8-bit adder. Used where area matters more than latency.
- Results are signalled with start/busy/done and hold stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width. Must be 2 or more. The bit counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  single clock; rising edge active.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; latched on the accepted start.
- B  input  WIDTH  subtrahend; latched on the accepted start.
- bin  input  1  borrow-in; latched on the accepted start.
- diff  output  WIDTH  result A - B - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 when unsigned A < B + bin.
- overflow  output  1  signed overflow of the subtraction.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - diff = 0, bout = 0, overflow = 0, busy = 0, done = 0.
  - Internal operand shift registers, carry and counter are cleared.
  - Reset mid-operation aborts the subtraction. No done pulse follows. Deassertion is synchronised by the flop behaviour only.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at edge E0: latch A into sa and B into sb; carry = ~bin; counter = 0; go to SHIFT.
  - start = 0: remain in IDLE. diff, bout and overflow hold their last values.
- SHIFT (busy = 1), one bit per edge:
  - s = sa[0] ^ ~sb[0] ^ carry.
  - carry' = majority(sa[0], ~sb[0], carry).
  - s shifts into the MSB of the result register, which shifts right.
  - sa and sb shift right.
  - counter increments.
  - After the WIDTH-th bit (edge E0+WIDTH), go to DONE.
- DONE (done = 1 for exactly one cycle, busy = 0):
  - diff = result register.
  - bout = ~carry_final.
  - overflow = (A[W-1] != B[W-1]) & (diff[W-1] != A[W-1]), using the latched operand MSBs.
  - These outputs update on the edge entering DONE. The next edge returns to IDLE.
- Latency:
  - done is high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 edges after start is sampled.
  - A new start can be accepted on the edge after DONE, giving a throughput of one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored; it is neither queued nor able to corrupt the operation.
- A, B and bin may change freely after E0; they are not re-sampled.
- diff, bout and overflow hold until the next DONE. They are not cleared on a new start.
- Boundary cases:
  - B = 0 with bin = 0 gives diff = A, bout = 0.
  - A = B gives diff = 0, overflow = 0.
  - The most negative minuend minus a positive value overflows.

Test Plan:
- A=0x36, B=0x0F, bin=0, start pulse -> done pulse at 9 edges after start; diff=0x27, bout=0, overflow=0; busy high for exactly 8 cycles.
- A=0x4D, B=0x4D, bin=0 -> diff=0x00, bout=0, overflow=0.
- A=0x00, B=0x01, bin=0 -> diff=0xFF, bout=1, overflow=0. Then A=0x80, B=0x01, bin=0 -> diff=0x7F, bout=0, overflow=1.
- A=0x10, B=0x05, bin=1 -> diff=0x0A, bout=0. Then A=0x7F, B=0xFF, bin=0 -> diff=0x80, bout=1, overflow=1.
- Start A=0x36, B=0x0F. At cycle 3, pulse start with A=0xFF, B=0x00 and change the inputs -> result is still diff=0x27 with a single done pulse. The next start accepted after DONE computes the new operands.
- Start an operation, drive rst_n low at cycle 4 (asynchronous, mid-cycle) -> all outputs drop to 0 immediately with no done pulse. After release, A=0x40, B=0xC0 -> diff=0x80, bout=1, overflow=1.
